// File: rtl/tri_arb_pkg.sv
// Shared definitions for the tri-state bus arbiter: FSM state type and
// default parameter values.
package tri_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } arb_state_e;

    localparam int DEF_NREQ      = 4;
    localparam int DEF_W         = 8;
    localparam int DEF_TA_CYCLES = 1;
    localparam int DEF_MAX_HOLD  = 4;

endpackage : tri_arb_pkg

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping from NREQ-1 back to 0.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic            valid_o
);

    logic [NREQ-1:0] rot_req;
    logic [NREQ-1:0] rot_first;
    logic            found;

    // Rotate so ptr_i lands on bit 0, take the lowest set bit, rotate back.
    always_comb begin
        rot_req   = NREQ'({req_i, req_i} >> ptr_i);
        rot_first = '0;
        found     = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && rot_req[i]) begin
                rot_first[i] = 1'b1;
                found        = 1'b1;
            end
        end
        gnt_o   = NREQ'(({rot_first, rot_first} << ptr_i) >> NREQ);
        valid_o = found;
    end

endmodule : rr_pick

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner selection for a shared tri-state bus with bounded hold
// time and a fixed all-drivers-off turnaround between owners.
module tri_bus_arbiter
    import tri_arb_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int W         = DEF_W,
    parameter int TA_CYCLES = DEF_TA_CYCLES,
    parameter int MAX_HOLD  = DEF_MAX_HOLD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] data_in,
    output logic [NREQ-1:0]   oe,
    output logic [NREQ-1:0]   grant,
    output logic [W-1:0]      bus_data,
    output logic              bus_z
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e      state_q;
    logic [NREQ-1:0] oe_q;
    logic [PW-1:0]   ptr_q;
    logic [7:0]      hold_cnt_q;
    logic [2:0]      turn_cnt_q;

    logic [NREQ-1:0] pick_gnt;
    logic            pick_valid;
    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   ptr_d;
    logic            owner_req;
    logic            others_req;
    logic            hold_full;
    logic            turn_last;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .valid_o (pick_valid)
    );

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) pick_idx = PW'(i);
        end
        ptr_d      = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        owner_req  = |(req & oe_q);
        others_req = |(req & ~oe_q);
        hold_full  = (hold_cnt_q == 8'(MAX_HOLD));
        turn_last  = (turn_cnt_q <= 3'd1);
    end

    // NOTE: state uses non-blocking assignments; the async reset clears every
    // register, which is what drops the enables without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            oe_q       <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            turn_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        state_q    <= OWN;
                        oe_q       <= pick_gnt;
                        ptr_q      <= ptr_d;
                        hold_cnt_q <= 8'd1;
                    end
                end
                OWN: begin
                    if (!owner_req || (hold_full && others_req)) begin
                        state_q    <= TURN;
                        oe_q       <= '0;
                        hold_cnt_q <= '0;
                        turn_cnt_q <= 3'(TA_CYCLES);
                    end else if (!hold_full) begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end
                end
                TURN: begin
                    if (!turn_last) begin
                        turn_cnt_q <= turn_cnt_q - 3'd1;
                    end else begin
                        turn_cnt_q <= '0;
                        if (pick_valid) begin
                            state_q    <= OWN;
                            oe_q       <= pick_gnt;
                            ptr_q      <= ptr_d;
                            hold_cnt_q <= 8'd1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    oe_q    <= '0;
                end
            endcase
        end
    end

    // oe_q is one-hot-or-zero, so at most one slice is selected.
    always_comb begin
        bus_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (oe_q[i]) bus_data = data_in[i*W +: W];
        end
    end

    assign oe    = oe_q;
    assign grant = oe_q;
    assign bus_z = ~|oe_q;

endmodule : tri_bus_arbiter

// File: tb/tb_tri_bus_arbiter.sv
// Bench for tri_bus_arbiter (NREQ=4, W=8, TA_CYCLES=1, MAX_HOLD=4): vector
// table, hand-written reset/turnaround sequences, and random traffic vs a model.
module tb_tri_bus_arbiter;

    localparam int NREQ      = 4;
    localparam int W         = 8;
    localparam int TA_CYCLES = 1;
    localparam int MAX_HOLD  = 4;
    localparam logic [31:0] D_ALL = 32'h44332211;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  oe;
    logic [3:0]  grant;
    logic [7:0]  bus_data;
    logic        bus_z;

    int checks   = 0;
    int failures = 0;

    tri_bus_arbiter #(
        .NREQ      (NREQ),
        .W         (W),
        .TA_CYCLES (TA_CYCLES),
        .MAX_HOLD  (MAX_HOLD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .data_in  (data_in),
        .oe       (oe),
        .grant    (grant),
        .bus_data (bus_data),
        .bus_z    (bus_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Ownership invariants, checked every cycle across all scenarios.
    logic [3:0] mon_prev_oe = '0;
    initial begin
        forever begin
            @(negedge clk);
            check("oe one-hot-or-zero", 32'($onehot0(oe)), 32'd1);
            check("no overlapping handover",
                  32'((|(oe & ~mon_prev_oe)) && (|(mon_prev_oe & ~oe))), 32'd0);
            mon_prev_oe = oe;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model: owner index, cycles held, float cycles left, search start.
    int m_owner, m_held, m_gap, m_ptr;

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_gap   = 0;
        m_ptr   = 0;
    endtask

    function automatic int model_pick(input logic [3:0] r);
        for (int k = 0; k < NREQ; k++) begin
            int c;
            c = (m_ptr + k) % NREQ;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [3:0] r);
        int w;
        if (m_owner >= 0) begin
            logic [3:0] others;
            others = r & ~(4'(1) << m_owner);
            if (!r[m_owner] || (m_held >= MAX_HOLD && others != 4'b0)) begin
                m_owner = -1;
                m_gap   = TA_CYCLES;
            end else if (m_held < MAX_HOLD) begin
                m_held++;
            end
        end else if (m_gap > 1) begin
            m_gap--;
        end else begin
            m_gap = 0;
            w = model_pick(r);
            if (w >= 0) begin
                m_owner = w;
                m_held  = 1;
                m_ptr   = (w + 1) % NREQ;
            end
        end
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  exp_oe;
        logic [7:0]  exp_bus;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [3:0] r, input logic [31:0] d,
                                input logic [3:0] e_oe, input logic [7:0] e_bus);
        vec_t v;
        v.req     = r;
        v.data    = d;
        v.exp_oe  = e_oe;
        v.exp_bus = e_bus;
        return v;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = 4'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] exp, input string name);
        req = r;
        @(negedge clk);
        check(name, 32'(oe), 32'(exp));
    endtask

    // Pull reset asynchronously while one requester owns the bus; the next
    // arbitration must start from requester 0 again.
    task automatic reset_mid(input logic [3:0] r, input string nm);
        apply_reset();
        req     = r;
        data_in = D_ALL;
        @(negedge clk);
        check({nm, " owner before reset"}, 32'(oe), 32'(r));
        #2 rst_n = 1'b0;
        #1;
        check({nm, " oe during reset"}, 32'(oe), 32'd0);
        check({nm, " bus_z during reset"}, 32'(bus_z), 32'd1);
        check({nm, " bus_data during reset"}, 32'(bus_data), 32'd0);
        req = 4'hF;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check({nm, " first grant after reset"}, 32'(oe), 32'h1);
    endtask

    initial begin
        logic [3:0] exp_oe;
        logic [7:0] exp_bus;

        // Round-robin sweep with forced release, then release, single owner, saturation.
        for (int o = 0; o < NREQ; o++) begin
            for (int k = 0; k < MAX_HOLD; k++)
                tbl.push_back(mk(4'hF, D_ALL, 4'(1 << o), 8'(17 * (o + 1))));
            tbl.push_back(mk(4'hF, D_ALL, 4'h0, 8'h00));
        end
        tbl.push_back(mk(4'hF, D_ALL, 4'b0001, 8'h11));
        tbl.push_back(mk(4'h0, D_ALL, 4'h0, 8'h00));
        tbl.push_back(mk(4'h0, D_ALL, 4'h0, 8'h00));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(4'b0100, 32'h00A50000, 4'b0100, 8'hA5));
        tbl.push_back(mk(4'h0, 32'h00A50000, 4'h0, 8'h00));
        tbl.push_back(mk(4'h0, 32'h00A50000, 4'h0, 8'h00));
        for (int k = 0; k < 10; k++) tbl.push_back(mk(4'b0010, 32'h0000C300, 4'b0010, 8'hC3));
        tbl.push_back(mk(4'h0, 32'h0000C300, 4'h0, 8'h00));
        tbl.push_back(mk(4'h0, 32'h0000C300, 4'h0, 8'h00));

        // Reset with all requests high.
        rst_n   = 1'b0;
        req     = 4'hF;
        data_in = D_ALL;
        @(negedge clk);
        @(negedge clk);
        check("reset oe", 32'(oe), 32'd0);
        check("reset grant", 32'(grant), 32'd0);
        check("reset bus_z", 32'(bus_z), 32'd1);
        check("reset bus_data", 32'(bus_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("first grant after reset", 32'(oe), 32'h1);

        apply_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            req     = tbl[i].req;
            data_in = tbl[i].data;
            @(negedge clk);
            check($sformatf("tbl[%0d] oe", i), 32'(oe), 32'(tbl[i].exp_oe));
            check($sformatf("tbl[%0d] grant", i), 32'(grant), 32'(tbl[i].exp_oe));
            check($sformatf("tbl[%0d] bus_data", i), 32'(bus_data), 32'(tbl[i].exp_bus));
            check($sformatf("tbl[%0d] bus_z", i), 32'(bus_z), 32'(tbl[i].exp_oe == 4'h0));
        end

        reset_mid(4'b1000, "mid-reset owner3");
        reset_mid(4'b0010, "mid-reset owner1");

        // Turnaround corners: a request dropped in TURN loses, a new one wins.
        apply_reset();
        data_in = D_ALL;
        for (int k = 0; k < MAX_HOLD; k++) step(4'b0011, 4'b0001, "turn seq hold");
        step(4'b0011, 4'b0000, "turn seq forced release");
        step(4'b0001, 4'b0001, "turn seq dropped req skipped");
        step(4'b0000, 4'b0000, "turn seq owner release");
        step(4'b0100, 4'b0100, "turn seq new req in TURN");
        step(4'b0000, 4'b0000, "turn seq release again");

        // Random traffic against the model, with occasional async resets.
        apply_reset();
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < NREQ; b++)
                if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
            data_in = $urandom();
            if ($urandom_range(0, 249) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                check("rnd async reset oe", 32'(oe), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                model_reset();
            end else begin
                model_step(req);
                @(negedge clk);
                exp_oe  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'h0;
                exp_bus = (m_owner >= 0) ? data_in[m_owner*W +: W] : 8'h00;
                check($sformatf("rnd[%0d] oe", c), 32'(oe), 32'(exp_oe));
                check($sformatf("rnd[%0d] grant", c), 32'(grant), 32'(exp_oe));
                check($sformatf("rnd[%0d] bus_data", c), 32'(bus_data), 32'(exp_bus));
                check($sformatf("rnd[%0d] bus_z", c), 32'(bus_z), 32'(exp_oe == 4'h0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_tri_bus_arbiter
